i2c_reg_bridge: RTL and testbench

- I2C target front end for the LED driver.
- Decodes serial I2C transactions on SCL/SDA and issues single-beat register writes and reads on the led_controller's parallel register bus (addr/data/w_en/r_en).
- Sits directly upstream of led_controller in the same 400 kHz clock domain.
- Provides a register pointer with optional auto-increment.

---
 rtl/i2c_reg_bridge.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_i2c_reg_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_bridge
// Purpose  : I2C target front end for the LED driver. Decodes SCL/SDA and
//            issues single-beat writes/reads on the led_controller register
//            bus. Holds a register pointer with optional auto-increment.
// Ports    : clk_400K, reset (async, active-high)
//            scl_in, sda_in   raw pad inputs (asynchronous)
//            sda_oe           1 = pull SDA low (open drain)
//            bus_addr/bus_wdata/bus_rdata/bus_w_en/bus_r_en  register bus
//            busy             high START..STOP when this target is addressed
// Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_bridge #(
    parameter logic [6:0] SLAVE_ADDR = 7'h62,
    parameter int         ADDR_BITS  = 4,
    parameter int         DATA_BITS  = 8,
    parameter int         NUM_REGS   = 13
) (
    input  logic                 clk_400K,
    input  logic                 reset,
    input  logic                 scl_in,
    input  logic                 sda_in,
    output logic                 sda_oe,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [DATA_BITS-1:0] bus_wdata,
    input  logic [DATA_BITS-1:0] bus_rdata,
    output logic                 bus_w_en,
    output logic                 bus_r_en,
    output logic                 busy
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RFETCH    = 4'd7,
        S_RDATA     = 4'd8,
        S_RDATA_ACK = 4'd9,
        S_IGNORE    = 4'd10
    } state_t;

    localparam logic [3:0]           c_BYTE_BITS = 4'(DATA_BITS);
    localparam logic [ADDR_BITS-1:0] c_LAST_REG  = ADDR_BITS'(NUM_REGS - 1);

    // Synchronisers idle high so a released bus never looks like an event.
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_cnt, w_cnt_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic [ADDR_BITS-1:0]   r_ptr, w_ptr_nxt;
    logic                   r_ai, w_ai_nxt;
    logic                   r_rw, w_rw_nxt;
    logic                   r_fetch, w_fetch_nxt;
    logic                   r_wr_req, w_wr_req_nxt;
    logic                   w_sda_oe_nxt, w_w_en_nxt, w_r_en_nxt, w_busy_nxt;
    logic [ADDR_BITS-1:0]   w_addr_nxt;
    logic [DATA_BITS-1:0]   w_wdata_nxt;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_byte_done, w_ptr_ok;
    logic [DATA_BITS-1:0] w_shift_in;

    assign w_scl_rise  = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall  = ~r_scl_s2 & r_scl_d;
    assign w_start     = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop      = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte_done = (r_cnt == c_BYTE_BITS);
    assign w_shift_in  = {r_shift[DATA_BITS-2:0], r_sda_s2};
    assign w_ptr_ok    = (int'(r_shift[ADDR_BITS-1:0]) < NUM_REGS);

    function automatic logic [ADDR_BITS-1:0] f_inc(input logic [ADDR_BITS-1:0] p);
        return (p == c_LAST_REG) ? '0 : p + ADDR_BITS'(1);
    endfunction

    always_ff @(posedge clk_400K or posedge reset) begin
        if (reset) begin
            r_scl_s1  <= 1'b1;
            r_scl_s2  <= 1'b1;
            r_scl_d   <= 1'b1;
            r_sda_s1  <= 1'b1;
            r_sda_s2  <= 1'b1;
            r_sda_d   <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_ai      <= 1'b0;
            r_rw      <= 1'b0;
            r_fetch   <= 1'b0;
            r_wr_req  <= 1'b0;
            sda_oe    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_w_en  <= 1'b0;
            bus_r_en  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_scl_s1  <= scl_in;
            r_scl_s2  <= r_scl_s1;
            r_scl_d   <= r_scl_s2;
            r_sda_s1  <= sda_in;
            r_sda_s2  <= r_sda_s1;
            r_sda_d   <= r_sda_s2;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_ai      <= w_ai_nxt;
            r_rw      <= w_rw_nxt;
            r_fetch   <= w_fetch_nxt;
            r_wr_req  <= w_wr_req_nxt;
            sda_oe    <= w_sda_oe_nxt;
            bus_addr  <= w_addr_nxt;
            bus_wdata <= w_wdata_nxt;
            bus_w_en  <= w_w_en_nxt;
            bus_r_en  <= w_r_en_nxt;
            busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_ptr_nxt    = r_ptr;
        w_ai_nxt     = r_ai;
        w_rw_nxt     = r_rw;
        w_fetch_nxt  = r_fetch;
        w_wr_req_nxt = 1'b0;
        w_sda_oe_nxt = sda_oe;
        w_addr_nxt   = bus_addr;
        w_wdata_nxt  = bus_wdata;
        w_w_en_nxt   = r_wr_req;   // strobe follows the address/data setup by one clock
        w_r_en_nxt   = 1'b0;
        w_busy_nxt   = busy;

        // Auto-increment after the write strobe has been issued.
        if (r_wr_req && r_ai) begin
            w_ptr_nxt = f_inc(r_ptr);
        end

        case (r_state)
            S_ADDR: begin
                if (w_scl_rise && !w_byte_done) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + 4'd1;
                end else if (w_scl_fall && w_byte_done) begin
                    if (r_shift[DATA_BITS-1:1] == SLAVE_ADDR) begin
                        w_rw_nxt     = r_shift[0];
                        w_busy_nxt   = 1'b1;
                        w_sda_oe_nxt = 1'b1;
                        w_state_nxt  = S_ADDR_ACK;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IGNORE;
                    end
                end
            end
            S_ADDR_ACK: begin
                // A read starts fetching during the ACK high phase so the first
                // data bit can replace the ACK on the following falling edge.
                if (r_rw) begin
                    if (w_scl_rise) begin
                        w_fetch_nxt = 1'b0;
                        w_state_nxt = S_RFETCH;
                    end
                end else if (w_scl_fall) begin
                    w_sda_oe_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_PTR;
                end
            end
            S_PTR: begin
                if (w_scl_rise && !w_byte_done) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + 4'd1;
                end else if (w_scl_fall && w_byte_done) begin
                    // An out-of-range pointer is refused and the old pointer kept.
                    if (w_ptr_ok) begin
                        w_ptr_nxt    = r_shift[ADDR_BITS-1:0];
                        w_ai_nxt     = r_shift[DATA_BITS-1];
                        w_sda_oe_nxt = 1'b1;
                        w_state_nxt  = S_PTR_ACK;
                    end else begin
                        w_state_nxt  = S_IGNORE;
                    end
                end
            end
            S_PTR_ACK: begin
                if (w_scl_fall) begin
                    w_sda_oe_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_WDATA;
                end
            end
            S_WDATA: begin
                if (w_scl_rise && !w_byte_done) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + 4'd1;
                end else if (w_scl_fall && w_byte_done) begin
                    w_sda_oe_nxt = 1'b1;
                    w_state_nxt  = S_WDATA_ACK;
                end
            end
            S_WDATA_ACK: begin
                if (w_scl_fall) begin
                    w_sda_oe_nxt = 1'b0;
                    w_addr_nxt   = r_ptr;
                    w_wdata_nxt  = r_shift;
                    w_wr_req_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_WDATA;
                end
            end
            S_RFETCH: begin
                if (!r_fetch) begin
                    w_addr_nxt  = r_ptr;
                    w_r_en_nxt  = 1'b1;
                    w_fetch_nxt = 1'b1;
                end else begin
                    // bus_r_en is high this clock; read data is valid now.
                    w_shift_nxt = bus_rdata;
                    w_fetch_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RDATA;
                end
            end
            S_RDATA: begin
                if (w_scl_fall) begin
                    if (!w_byte_done) begin
                        w_sda_oe_nxt = ~r_shift[DATA_BITS-1];
                        w_shift_nxt  = {r_shift[DATA_BITS-2:0], 1'b0};
                        w_cnt_nxt    = r_cnt + 4'd1;
                    end else begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_RDATA_ACK;
                    end
                end
            end
            S_RDATA_ACK: begin
                if (w_scl_rise) begin
                    if (!r_sda_s2) begin
                        if (r_ai) begin
                            w_ptr_nxt = f_inc(r_ptr);
                        end
                        w_fetch_nxt = 1'b0;
                        w_state_nxt = S_RFETCH;
                    end else begin
                        w_state_nxt = S_IGNORE;
                    end
                end
            end
            S_IGNORE: begin
                w_sda_oe_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Bus conditions override whatever the byte engine was doing.
        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_cnt_nxt    = '0;
        end else if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_reg_bridge
// Purpose  : Self-checking bench for i2c_reg_bridge. Acts as I2C controller
//            and as the led_controller register file; expected values come
//            from a register-file/pointer model kept here.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_bridge;

    localparam int Q    = 4;   // clocks per SCL quarter period (SCL = clk/16)
    localparam int NREG = 13;

    logic       clk_400K = 1'b0;
    logic       reset    = 1'b1;
    logic       scl_drv  = 1'b1;
    logic       sda_drv  = 1'b1;
    logic       mem_clr  = 1'b1;
    logic       sda_line;
    logic       sda_oe, bus_w_en, bus_r_en, busy;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;

    logic [7:0]  mem [16];          // register file stand-in (retains contents)
    logic [11:0] wlog [$];          // observed {addr, data} writes
    int n_wen = 0, n_ren = 0, n_oe = 0, n_busy = 0, n_clash = 0, n_wide = 0;
    logic prev_w = 1'b0, prev_r = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [7:0] exp_mem [16];
    int         exp_ptr = 0;
    logic       exp_ai  = 1'b0;

    assign sda_line  = sda_drv & ~sda_oe;
    assign bus_rdata = mem[bus_addr];

    always #5 clk_400K = ~clk_400K;

    i2c_reg_bridge dut (
        .clk_400K (clk_400K),
        .reset    (reset),
        .scl_in   (scl_drv),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_w_en (bus_w_en),
        .bus_r_en (bus_r_en),
        .busy     (busy)
    );

    always @(posedge clk_400K) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (bus_w_en) begin
            mem[bus_addr] <= bus_wdata;
        end
        if (bus_w_en) begin
            n_wen <= n_wen + 1;
            wlog.push_back({bus_addr, bus_wdata});
        end
        if (bus_r_en) n_ren <= n_ren + 1;
        if (sda_oe) n_oe <= n_oe + 1;
        if (busy) n_busy <= n_busy + 1;
        if (bus_w_en && bus_r_en) n_clash <= n_clash + 1;
        if ((bus_w_en && prev_w) || (bus_r_en && prev_r)) n_wide <= n_wide + 1;
        prev_w <= bus_w_en;
        prev_r <= bus_r_en;
    end

    // ---------------- model ----------------
    function automatic int f_nxt(input int p);
        return (p == NREG - 1) ? 0 : p + 1;
    endfunction

    task automatic model_ctrl(input logic [7:0] c);
        if (int'(c[3:0]) < NREG) begin
            exp_ptr = int'(c[3:0]);
            exp_ai  = c[7];
        end
    endtask

    task automatic model_write(input logic [7:0] d, output logic [11:0] e);
        e = {4'(exp_ptr), d};
        exp_mem[exp_ptr] = d;
        if (exp_ai) exp_ptr = f_nxt(exp_ptr);
    endtask

    task automatic model_read(input logic nack, output logic [7:0] e);
        e = exp_mem[exp_ptr];
        if (!nack && exp_ai) exp_ptr = f_nxt(exp_ptr);
    endtask

    // ---------------- I2C controller ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_400K);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(2*Q);
        sda_drv = 1'b0; wait_clk(2*Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(2*Q);
        sda_drv = 1'b1; wait_clk(2*Q);
    endtask

    task automatic i2c_wbit(input logic b);
        sda_drv = b;    wait_clk(Q);
        scl_drv = 1'b1; wait_clk(2*Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_rbit(output logic b);
        sda_drv = 1'b1; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        b = sda_line;   wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_wbits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) i2c_wbit(b[i]);
    endtask

    task automatic i2c_wbyte(input logic [7:0] b, output logic ack);
        i2c_wbits(b, 8);
        i2c_rbit(ack);
    endtask

    task automatic i2c_rbyte(input logic nack, output logic [7:0] b);
        logic bit_v;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            i2c_rbit(bit_v);
            b = {b[6:0], bit_v};
        end
        i2c_wbit(nack);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (sda_oe !== 1'b0)     begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        checks++; if (bus_addr !== 4'h0)   begin errors++; $display("FAIL reset_bus_addr got %h want 0", bus_addr); end
        checks++; if (bus_wdata !== 8'h00) begin errors++; $display("FAIL reset_bus_wdata got %h want 00", bus_wdata); end
        checks++; if (bus_w_en !== 1'b0)   begin errors++; $display("FAIL reset_w_en got %b want 0", bus_w_en); end
        checks++; if (bus_r_en !== 1'b0)   begin errors++; $display("FAIL reset_r_en got %b want 0", bus_r_en); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single_write(input logic [7:0] d);
        logic a0, a1, a2;
        logic [11:0] e;
        int w0;
        w0 = wlog.size();
        i2c_start();
        i2c_wbyte(8'hC4, a0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        i2c_wbyte(8'h02, a1); model_ctrl(8'h02);
        i2c_wbyte(d, a2);     model_write(d, e);
        i2c_stop();
        wait_clk(4);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL single_acks got %b want 000", {a0, a1, a2}); end
        checks++;
        if (wlog.size() - w0 != 1) begin
            errors++; $display("FAIL single_nwrites got %0d want 1", wlog.size() - w0);
        end else begin
            checks++; if (wlog[w0] !== e) begin errors++; $display("FAIL single_write got %h want %h", wlog[w0], e); end
        end
        checks++; if (mem[2] !== exp_mem[2]) begin errors++; $display("FAIL single_readback got %h want %h", mem[2], exp_mem[2]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_stop got %b want 0", busy); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0]  d1 [4] = '{8'h40, 8'h80, 8'hC0, 8'hFF};
        logic [7:0]  d2 [2] = '{8'hAA, 8'hBB};
        logic [11:0] e [6];
        logic        a, nak;
        int w0;
        w0 = wlog.size();
        nak = 1'b0;
        i2c_start(); i2c_wbyte(8'hC4, a); nak |= a;
        i2c_wbyte(8'h82, a); nak |= a; model_ctrl(8'h82);
        for (int i = 0; i < 4; i++) begin i2c_wbyte(d1[i], a); nak |= a; model_write(d1[i], e[i]); end
        i2c_stop();
        i2c_start(); i2c_wbyte(8'hC4, a); nak |= a;
        i2c_wbyte(8'h8C, a); nak |= a; model_ctrl(8'h8C);
        for (int i = 0; i < 2; i++) begin i2c_wbyte(d2[i], a); nak |= a; model_write(d2[i], e[4+i]); end
        i2c_stop();
        wait_clk(4);
        checks++; if (nak !== 1'b0) begin errors++; $display("FAIL burst_acks got nack want all ack"); end
        checks++;
        if (wlog.size() - w0 != 6) begin
            errors++; $display("FAIL burst_nwrites got %0d want 6", wlog.size() - w0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wlog[w0+i] !== e[i]) begin errors++; $display("FAIL burst_write%0d got %h want %h", i, wlog[w0+i], e[i]); end
            end
        end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] r0, r1, e0, e1;
        int wen0, ren0;
        wen0 = n_wen; ren0 = n_ren;
        i2c_start(); i2c_wbyte(8'hC4, a0);
        i2c_wbyte(8'h82, a1); model_ctrl(8'h82);
        i2c_start(); i2c_wbyte(8'hC5, a2);
        i2c_rbyte(1'b0, r0); model_read(1'b0, e0);
        i2c_rbyte(1'b1, r1); model_read(1'b1, e1);
        i2c_stop();
        wait_clk(4);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL read_acks got %b want 000", {a0, a1, a2}); end
        checks++; if (r0 !== e0) begin errors++; $display("FAIL read_byte0 got %h want %h", r0, e0); end
        checks++; if (r1 !== e1) begin errors++; $display("FAIL read_byte1 got %h want %h", r1, e1); end
        checks++; if (n_ren - ren0 != 2) begin errors++; $display("FAIL read_r_en_count got %0d want 2", n_ren - ren0); end
        checks++; if (n_wen - wen0 != 0) begin errors++; $display("FAIL read_w_en_count got %0d want 0", n_wen - wen0); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1, a2;
        int oe0, busy0, wen0, ren0;
        oe0 = n_oe; busy0 = n_busy; wen0 = n_wen; ren0 = n_ren;
        i2c_start(); i2c_wbyte(8'hC6, a0); i2c_wbyte(8'h02, a1); i2c_wbyte(8'h55, a2);
        i2c_stop();
        wait_clk(4);
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wrong_acks got %b want 111", {a0, a1, a2}); end
        checks++; if (n_oe != oe0) begin errors++; $display("FAIL wrong_sda_oe cycles got %0d want 0", n_oe - oe0); end
        checks++; if (n_busy != busy0) begin errors++; $display("FAIL wrong_busy cycles got %0d want 0", n_busy - busy0); end
        checks++; if ((n_wen - wen0) + (n_ren - ren0) != 0) begin errors++; $display("FAIL wrong_strobes got %0d want 0", (n_wen - wen0) + (n_ren - ren0)); end
    endtask

    task automatic test_bad_ptr();
        logic a0, a1, a2, a3, a4;
        logic [7:0] r, e;
        int wen0;
        wen0 = n_wen;
        i2c_start(); i2c_wbyte(8'hC4, a0);
        i2c_wbyte(8'h0F, a1); model_ctrl(8'h0F);
        i2c_wbyte(8'h11, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b011) begin errors++; $display("FAIL badptr_acks got %b want 011", {a0, a1, a2}); end
        i2c_start(); i2c_wbyte(8'hC4, a3);
        i2c_wbyte(8'h03, a4); model_ctrl(8'h03);
        i2c_wbits(8'h5A, 4);
        i2c_stop();
        wait_clk(4);
        checks++; if ({a3, a4} !== 2'b00) begin errors++; $display("FAIL partial_acks got %b want 00", {a3, a4}); end
        checks++; if (n_wen != wen0) begin errors++; $display("FAIL badptr_writes got %0d want 0", n_wen - wen0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got %b want 0", busy); end
        i2c_start(); i2c_wbyte(8'hC5, a0);
        i2c_rbyte(1'b1, r); model_read(1'b1, e);
        i2c_stop();
        checks++; if (r !== e) begin errors++; $display("FAIL partial_readback got %h want %h", r, e); end
    endtask

    task automatic test_reset_mid();
        logic a;
        logic [7:0] r, e;
        int w0;
        i2c_start(); i2c_wbyte(8'hC4, a);
        i2c_wbyte(8'h85, a); model_ctrl(8'h85);
        i2c_wbits(8'hA7, 4);
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        w0 = wlog.size();
        #2 reset = 1'b1;
        #1;
        checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL midrst_sda_oe got %b want 0", sda_oe); end
        checks++; if (bus_w_en !== 1'b0) begin errors++; $display("FAIL midrst_w_en got %b want 0", bus_w_en); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (bus_addr !== 4'h0) begin errors++; $display("FAIL midrst_bus_addr got %h want 0", bus_addr); end
        wait_clk(2);
        sda_drv = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        exp_ptr = 0; exp_ai = 1'b0;
        wait_clk(4);
        checks++; if (wlog.size() != w0) begin errors++; $display("FAIL midrst_writes got %0d want 0", wlog.size() - w0); end
        i2c_start(); i2c_wbyte(8'hC5, a);
        i2c_rbyte(1'b1, r); model_read(1'b1, e);
        i2c_stop();
        checks++; if (r !== e) begin errors++; $display("FAIL midrst_ptr_read got %h want %h", r, e); end
        test_single_write(8'h40);
    endtask

    task automatic test_random();
        logic [7:0]  ctrl, d, r, er;
        logic [11:0] e [8];
        logic        a, nak;
        int p, n, w0;
        for (int it = 0; it < 5; it++) begin
            p = $urandom_range(0, NREG - 1);
            n = $urandom_range(1, 6);
            ctrl = {1'($urandom_range(0, 1)), 3'b000, 4'(p)};
            w0 = wlog.size();
            nak = 1'b0;
            i2c_start(); i2c_wbyte(8'hC4, a); nak |= a;
            i2c_wbyte(ctrl, a); nak |= a; model_ctrl(ctrl);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                i2c_wbyte(d, a); nak |= a;
                model_write(d, e[i]);
            end
            i2c_stop();
            wait_clk(4);
            checks++; if (nak !== 1'b0) begin errors++; $display("FAIL rand%0d_acks got nack want all ack", it); end
            checks++;
            if (wlog.size() - w0 != n) begin
                errors++; $display("FAIL rand%0d_nwrites got %0d want %0d", it, wlog.size() - w0, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (wlog[w0+i] !== e[i]) begin errors++; $display("FAIL rand%0d_write%0d got %h want %h", it, i, wlog[w0+i], e[i]); end
                end
            end
            i2c_start(); i2c_wbyte(8'hC4, a);
            i2c_wbyte(ctrl, a); model_ctrl(ctrl);
            i2c_start(); i2c_wbyte(8'hC5, a);
            for (int i = 0; i < n; i++) begin
                i2c_rbyte(1'(i == n - 1), r);
                model_read(1'(i == n - 1), er);
                checks++;
                if (r !== er) begin errors++; $display("FAIL rand%0d_read%0d got %h want %h", it, i, r, er); end
            end
            i2c_stop();
        end
    endtask

    task automatic test_invariants();
        checks++; if (n_clash != 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", n_clash); end
        checks++; if (n_wide != 0)  begin errors++; $display("FAIL strobe_width got %0d wide cycles want 0", n_wide); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        wait_clk(4);
        mem_clr = 1'b0;
        reset   = 1'b0;
        wait_clk(4);
        test_reset();
        test_single_write(8'h40);
        test_burst_wrap();
        test_read();
        test_wrong_addr();
        test_bad_ptr();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
